cpu_run_sequencer: RTL and testbench

//  Sequences the 4-bit CPU. Loads a program into the 16x4 instruction memory over a valid/ready port,

---
 rtl/cpu_run_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_cpu_run_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_sequencer.sv
// cpu_run_sequencer: loads the 16x4 imem, holds the CPU in reset, then runs it free or single-step.
// Latency: an accepted load beat appears on imem_we/imem_waddr/imem_wdata one cycle later; control pulses act next cycle.
// Backpressure: ld_ready is high only in IDLE; beats offered in any other state are left pending.
//
// Optional feature macro: BREAKPOINT_EN (adds bp_en / bp_addr and a PC breakpoint in RUN).
//
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   ld_valid/ld_ready/ld_addr/ld_data   program load port (valid/ready, 1 beat/cycle)
//   start, stop, step, abort     single-cycle control pulses
//   imem_we/imem_waddr/imem_wdata      registered instruction-memory write port
//   cpu_rst, cpu_en              CPU reset (registered) and clock enable (combinational)
//   cpu_pc, cpu_halted           CPU status inputs
//   busy, done, timeout          run status (registered)
//   cycle_count                  enabled CPU cycles since the last BOOT, saturating
//   bp_en, bp_addr               breakpoint controls (BREAKPOINT_EN builds only)

module cpu_run_sequencer #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 4,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int MAX_CYCLES   = 0
) (
  input  logic              clk,
  input  logic              reset,
  // program load port
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  // control pulses
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              abort,
`ifdef BREAKPOINT_EN
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
`endif
  // instruction memory write port
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  // CPU control / status
  output logic              cpu_rst,
  output logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_pc,
  input  logic              cpu_halted,
  // run status
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOOT  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Boot counter only needs to reach RESET_CYCLES-1.
  localparam int BW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(RESET_CYCLES - 1);

  // Watchdog compare is done one bit wider than the counter so a limit equal
  // to 2**CNT_W still compares correctly against a saturated count.
  localparam bit               WD_ON  = (MAX_CYCLES != 0);
  localparam logic [CNT_W:0]   WD_LIM = (CNT_W + 1)'(MAX_CYCLES);

  state_t          state;
  state_t          nxt;
  logic [BW-1:0]   boot_cnt;
  logic            ld_fire;
  logic            bp_hit;
  logic            run_en;
  logic            wd_at_max;
  logic            wd_last;
  logic            boot_entry;
  logic [CNT_W:0]  count_ext;

  assign ld_ready = (state == S_IDLE);
  assign ld_fire  = ld_valid && ld_ready;

`ifdef BREAKPOINT_EN
  // Set for the first RUN cycle after a resume so the instruction parked at
  // the breakpoint address executes instead of re-triggering the breakpoint.
  logic resume_skip;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resume_skip <= 1'b0;
    end else begin
      resume_skip <= (state == S_PAUSE) && (nxt == S_RUN);
    end
  end

  assign bp_hit = (state == S_RUN) && bp_en && (cpu_pc == bp_addr) && !resume_skip;
`else
  logic unused_pc;
  assign unused_pc = ^cpu_pc;
  assign bp_hit    = 1'b0;
`endif

  assign count_ext = {1'b0, cycle_count};

  // Count already at the limit (possible after single steps): no further
  // enables in RUN, leave for DONE immediately.
  assign wd_at_max = WD_ON && (count_ext >= WD_LIM);

  // RUN enable: a halted CPU, a breakpoint hit or an exhausted watchdog all
  // suppress execution for this cycle.
  assign run_en  = (state == S_RUN) && !cpu_halted && !bp_hit && !wd_at_max;

  // This enable brings the count to the limit, so it is the last one.
  assign wd_last = WD_ON && run_en && ((count_ext + 1'b1) >= WD_LIM);

  // cpu_rst is only low in RUN/PAUSE/STEP/DONE, so cpu_en (RUN/STEP only)
  // can never overlap CPU reset.
  assign cpu_en = run_en || (state == S_STEP);

  assign boot_entry = (nxt == S_BOOT) && (state != S_BOOT);

  // Next-state decode; abort has the highest priority in every state.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: begin
        if (abort)      nxt = S_IDLE;
        else if (start) nxt = S_BOOT;
      end
      S_BOOT: begin
        if (abort)                       nxt = S_IDLE;
        else if (boot_cnt == BOOT_LAST)  nxt = S_RUN;
      end
      S_RUN: begin
        if (abort)                      nxt = S_IDLE;
        else if (cpu_halted)            nxt = S_DONE;
        else if (bp_hit)                nxt = S_PAUSE;
        else if (wd_at_max || wd_last)  nxt = S_DONE;
        else if (stop)                  nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (abort)      nxt = S_IDLE;
        else if (step)  nxt = cpu_halted ? S_DONE : S_STEP;
        else if (start) nxt = S_RUN;
      end
      S_STEP: begin
        if (abort) nxt = S_IDLE;
        else       nxt = S_PAUSE;
      end
      S_DONE: begin
        if (abort)      nxt = S_IDLE;
        else if (start) nxt = S_BOOT;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // State register and registered outputs. Outputs are derived from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      boot_cnt    <= '0;
      cpu_rst     <= 1'b1;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= nxt;

      // Load beats are written exactly one cycle after acceptance; the
      // address/data hold their last value when no beat is accepted.
      imem_we <= ld_fire;
      if (ld_fire) begin
        imem_waddr <= ld_addr;
        imem_wdata <= ld_data;
      end

      cpu_rst <= (nxt == S_IDLE) || (nxt == S_BOOT);
      busy    <= (nxt == S_BOOT) || (nxt == S_RUN) || (nxt == S_PAUSE) || (nxt == S_STEP);
      done    <= (nxt == S_DONE);

      // Entering DONE from RUN without a halt can only be the watchdog
      // (halt outranks it, abort goes to IDLE). Held while in DONE.
      if (nxt == S_DONE) begin
        if (state == S_DONE) timeout <= timeout;
        else                 timeout <= (state == S_RUN) && !cpu_halted;
      end else begin
        timeout <= 1'b0;
      end

      if (boot_entry) begin
        boot_cnt    <= '0;
        cycle_count <= '0;
      end else begin
        if (state == S_BOOT) boot_cnt <= boot_cnt + 1'b1;
        if (cpu_en && !(&cycle_count)) cycle_count <= cycle_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
module tb_cpu_run_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [3:0]  ld_addr = 4'd0;
  logic [3:0]  ld_data = 4'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic        abort = 1'b0;
  logic        imem_we;
  logic [3:0]  imem_waddr;
  logic [3:0]  imem_wdata;
  logic        cpu_rst;
  logic        cpu_en;
  logic [3:0]  cpu_pc;
  logic        cpu_halted;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;
`ifdef BREAKPOINT_EN
  logic        bp_en = 1'b0;
  logic [3:0]  bp_addr = 4'd0;
`endif

  int checks = 0;
  int errors = 0;

  // Minimal CPU stand-in: PC advances once per enabled cycle, halts at hlt_pc.
  logic [3:0] pc = 4'd0;
  logic       hlt_on = 1'b0;
  logic [3:0] hlt_pc = 4'd0;
  int         en_cnt = 0;

  assign cpu_pc     = pc;
  assign cpu_halted = hlt_on && (pc == hlt_pc);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_rst) pc <= 4'd0;
    else if (cpu_en) pc <= pc + 4'd1;
    if (cpu_en) en_cnt <= en_cnt + 1;
  end

  cpu_run_sequencer #(
    .ADDR_W(4), .DATA_W(4), .RESET_CYCLES(2), .CNT_W(16), .MAX_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .stop(stop), .step(step), .abort(abort),
`ifdef BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr),
`endif
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_pc(cpu_pc), .cpu_halted(cpu_halted),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  task automatic test_reset;
    @(negedge clk);
    checks++; if ({cpu_rst, cpu_en, imem_we, busy, done, timeout, ld_ready} !== 7'b1000001) begin
      errors++; $display("FAIL reset_flags got %b want 1000001", {cpu_rst, cpu_en, imem_we, busy, done, timeout, ld_ready}); end
    checks++; if ({imem_waddr, imem_wdata, cycle_count} !== 24'd0) begin
      errors++; $display("FAIL reset_regs got %h want 000000", {imem_waddr, imem_wdata, cycle_count}); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({cpu_rst, busy, done, ld_ready} !== 4'b1001) begin
      errors++; $display("FAIL idle_after_reset got %b want 1001", {cpu_rst, busy, done, ld_ready}); end
  endtask

  task automatic test_load;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        checks++; if ({imem_we, imem_waddr, imem_wdata} !== {1'b1, 4'(i - 1), 4'(16 - i)}) begin
          errors++; $display("FAIL load_beat%0d got we=%b a=%0d d=%0d want we=1 a=%0d d=%0d",
                              i - 1, imem_we, imem_waddr, imem_wdata, i - 1, 16 - i); end
      end
      if (i < 16) begin
        ld_valid = 1'b1; ld_addr = 4'(i); ld_data = 4'(15 - i);
        checks++; if (ld_ready !== 1'b1) begin
          errors++; $display("FAIL load_ready%0d got %b want 1", i, ld_ready); end
      end else begin
        ld_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (imem_we !== 1'b0) begin
      errors++; $display("FAIL load_we_end got %b want 0", imem_we); end
  endtask

  task automatic test_run_halt;
    int base, rst_cycles, n;
    hlt_on = 1'b1; hlt_pc = 4'd5; base = en_cnt;
    // beat and start in the same cycle
    ld_valid = 1'b1; ld_addr = 4'd3; ld_data = 4'd9; start = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; start = 1'b0;
    checks++; if ({imem_we, imem_waddr, imem_wdata, cpu_rst, busy} !== {1'b1, 4'd3, 4'd9, 1'b1, 1'b1}) begin
      errors++; $display("FAIL boot_write got we=%b a=%0d d=%0d rst=%b busy=%b want 1 3 9 1 1",
                          imem_we, imem_waddr, imem_wdata, cpu_rst, busy); end
    rst_cycles = 1;
    n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      if (cpu_rst) rst_cycles++; else break;
    end
    checks++; if (rst_cycles !== 2) begin
      errors++; $display("FAIL boot_len got %0d want 2", rst_cycles); end
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    checks++; if (done !== 1'b1) begin
      errors++; $display("FAIL halt_done got %b want 1", done); end
    checks++; if ({timeout, busy, cpu_en, cpu_rst} !== 4'b0000) begin
      errors++; $display("FAIL halt_flags got %b want 0000", {timeout, busy, cpu_en, cpu_rst}); end
    checks++; if (cycle_count !== 16'd5 || (en_cnt - base) !== 5) begin
      errors++; $display("FAIL halt_count got cnt=%0d en=%0d want 5 5", cycle_count, en_cnt - base); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    hlt_on = 1'b0;
  endtask

  task automatic test_step;
    int base, n;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (cpu_rst && n < 20) begin @(negedge clk); n++; end
    base = en_cnt;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    checks++; if ({busy, cpu_rst, cpu_en} !== 3'b100 || cycle_count !== 16'd1) begin
      errors++; $display("FAIL pause_entry got b/r/e=%b cnt=%0d want 100 1", {busy, cpu_rst, cpu_en}, cycle_count); end
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    checks++; if (cpu_en !== 1'b0 || busy !== 1'b1 || cycle_count !== 16'd1) begin
      errors++; $display("FAIL pause_stop_ignored got en=%b busy=%b cnt=%0d want 0 1 1", cpu_en, busy, cycle_count); end
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; @(negedge clk); step = 1'b0;
      checks++; if (cpu_en !== 1'b1) begin
        errors++; $display("FAIL step%0d_en got %b want 1", k, cpu_en); end
      @(negedge clk);
      checks++; if (cpu_en !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL step%0d_single got en=%b busy=%b want 0 1", k, cpu_en, busy); end
      @(negedge clk);
      @(negedge clk);
    end
    checks++; if (cycle_count !== 16'd4 || (en_cnt - base) !== 4) begin
      errors++; $display("FAIL step_count got cnt=%0d en=%0d want 4 4", cycle_count, en_cnt - base); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic test_watchdog;
    int base, n;
    hlt_on = 1'b0; base = en_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    checks++; if ({done, timeout} !== 2'b11) begin
      errors++; $display("FAIL wd_done got done=%b timeout=%b want 1 1", done, timeout); end
    checks++; if (cycle_count !== 16'd8 || (en_cnt - base) !== 8) begin
      errors++; $display("FAIL wd_count got cnt=%0d en=%0d want 8 8", cycle_count, en_cnt - base); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if ({timeout, done, cpu_rst, busy} !== 4'b0011 || cycle_count !== 16'd0) begin
      errors++; $display("FAIL wd_rerun got t/d/r/b=%b cnt=%0d want 0011 0", {timeout, done, cpu_rst, busy}, cycle_count); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++; if ({busy, cpu_rst, ld_ready} !== 3'b011) begin
      errors++; $display("FAIL boot_abort got %b want 011", {busy, cpu_rst, ld_ready}); end
  endtask

  task automatic test_abort;
    int n;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (cpu_rst && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (cpu_en !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_pre_run got en=%b busy=%b want 1 1", cpu_en, busy); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++; if ({cpu_rst, ld_ready, busy, cpu_en, done} !== 5'b11000) begin
      errors++; $display("FAIL abort_run got %b want 11000", {cpu_rst, ld_ready, busy, cpu_en, done}); end
  endtask

  task automatic test_async_reset;
    ld_valid = 1'b1; ld_addr = 4'd7; ld_data = 4'd5; start = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0; start = 1'b0;
    checks++; if ({imem_we, imem_waddr, imem_wdata, busy} !== {1'b1, 4'd7, 4'd5, 1'b1}) begin
      errors++; $display("FAIL areset_pre got we=%b a=%0d d=%0d busy=%b want 1 7 5 1", imem_we, imem_waddr, imem_wdata, busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({cpu_rst, cpu_en, imem_we, busy, done, timeout, ld_ready} !== 7'b1000001) begin
      errors++; $display("FAIL areset_flags got %b want 1000001", {cpu_rst, cpu_en, imem_we, busy, done, timeout, ld_ready}); end
    checks++; if ({imem_waddr, imem_wdata, cycle_count} !== 24'd0) begin
      errors++; $display("FAIL areset_regs got %h want 000000", {imem_waddr, imem_wdata, cycle_count}); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

`ifdef BREAKPOINT_EN
  task automatic test_breakpoint;
    int base, n;
    hlt_on = 1'b1; hlt_pc = 4'd6; bp_en = 1'b1; bp_addr = 4'd4; base = en_cnt;
    start = 1'b1; @(negedge clk); start = 1'b0;
    n = 0;
    while (!(busy && !cpu_rst && !cpu_en) && n < 40) begin @(negedge clk); n++; end
    checks++; if (cpu_pc !== 4'd4 || (en_cnt - base) !== 4) begin
      errors++; $display("FAIL bp_stop got pc=%0d en=%0d want 4 4", cpu_pc, en_cnt - base); end
    @(negedge clk);
    checks++; if (cpu_pc !== 4'd4 || cpu_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL bp_pause got pc=%0d en=%b busy=%b want 4 0 1", cpu_pc, cpu_en, busy); end
    start = 1'b1; @(negedge clk); start = 1'b0;
    checks++; if (cpu_en !== 1'b1 || cpu_pc !== 4'd4) begin
      errors++; $display("FAIL bp_resume got en=%b pc=%0d want 1 4", cpu_en, cpu_pc); end
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    checks++; if ({done, timeout} !== 2'b10 || cpu_pc !== 4'd6 || cycle_count !== 16'd6 || (en_cnt - base) !== 6) begin
      errors++; $display("FAIL bp_finish got d/t=%b pc=%0d cnt=%0d en=%0d want 10 6 6 6",
                          {done, timeout}, cpu_pc, cycle_count, en_cnt - base); end
    bp_en = 1'b0; hlt_on = 1'b0;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_run_halt();
    test_step();
    test_watchdog();
    test_abort();
    test_async_reset();
`ifdef BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
